mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single data-cache request port between load-unit requests and committed stores draining from the store data queue (SDQ).
- Sequences the SDQ drain: pulses the SDQ issue enable, captures the issued entry, writes it to the cache, then clears the SDQ entry once the cache acknowledges.
- Loads have priority. A starvation counter and an SDQ-full override guarantee store forward progress.
- Only one cache transaction is outstanding at a time.

Parameters:
- TAG_W, 4, width of the load tag returned with load data.
- SDQ_ENTRIES, 8, SDQ depth; sets index width IDX_W = $clog2(SDQ_ENTRIES).
- STARVE_LIMIT, 4, consecutive load grants allowed while a store is pending before a store is forced.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  pipeline flush; squashes the in-flight load only.
- ld_req_vld_i  in  1  load request valid.
- ld_req_rdy_o  out  1  load request accepted this cycle.
- ld_req_addr_i  in  32  load address.
- ld_req_tag_i  in  TAG_W  load tag.
- ld_rsp_vld_o  out  1  load data valid (registered).
- ld_rsp_data_o  out  32  load data.
- ld_rsp_tag_o  out  TAG_W  tag of the returned load.
- st_pending_i  in  1  SDQ head is valid, address-valid and committed.
- sdq_full_i  in  1  SDQ full.
- sdq_issue_en_o  out  1  one-cycle pulse requesting the SDQ head.
- sdq_issue_vld_i  in  1  SDQ issued entry valid; arrives 1 cycle after sdq_issue_en_o.
- sdq_issue_addr_i  in  32  issued store address.
- sdq_issue_data_i  in  32  issued store data.
- sdq_issue_idx_i  in  IDX_W  SDQ index of the issued store.
- sdq_clear_vld_o  out  1  clear-entry pulse to the SDQ (registered).
- sdq_clear_idx_o  out  IDX_W  index to clear.
- dc_req_vld_o  out  1  cache request valid.
- dc_req_rdy_i  in  1  cache ready.
- dc_req_we_o  out  1  1 = store, 0 = load.
- dc_req_addr_o  out  32  cache address.
- dc_req_wdata_o  out  32  store data.
- dc_rsp_vld_i  in  1  cache response or ack valid.
- dc_rsp_data_i  in  32  cache read data.

Behaviour:
- Reset (rst_ni = 0, asynchronous):
  - FSM goes to IDLE; starve_cnt = 0; squash flag = 0.
  - All outputs are 0.
  - Capture registers (address, data, tag, index) are 0.
- FSM states: IDLE, LD_REQ, LD_RSP, ST_FETCH, ST_REQ, ST_RSP.
- IDLE, store selection:
  - store_sel = st_pending_i & (~ld_req_vld_i | sdq_full_i | starve_cnt == STARVE_LIMIT).
  - If store_sel: sdq_issue_en_o = 1 (combinational, this cycle only); next state ST_FETCH.
- IDLE, load selection:
  - Load is taken when ld_req_vld_i & ~store_sel & ~flush_i.
  - ld_req_rdy_o = 1 combinationally; capture address and tag; next state LD_REQ.
  - ld_req_rdy_o is 0 in every other state and cycle.
- starve_cnt rules:
  - Load granted while st_pending_i = 1: increment, saturating at STARVE_LIMIT.
  - Store selected, or st_pending_i = 0: clear to 0.
- LD_REQ:
  - dc_req_vld_o = 1, dc_req_we_o = 0, dc_req_addr_o = captured address; these hold stable until dc_req_rdy_i.
  - On dc_req_rdy_i: next state LD_RSP.
  - flush_i before the handshake: drop the load, return to IDLE, no cache request issued.
- LD_RSP:
  - Wait for dc_rsp_vld_i.
  - If flush_i is seen in this state (including the response cycle), set the squash flag.
  - On dc_rsp_vld_i, if not squashed: next cycle ld_rsp_vld_o = 1 with dc_rsp_data_i and the captured tag.
  - On dc_rsp_vld_i, if squashed: no response is produced.
  - Either way, clear squash and return to IDLE.
- ST_FETCH:
  - If sdq_issue_vld_i: capture address, data and index; next state ST_REQ.
  - Otherwise (SDQ declined): return to IDLE. No retry counter.
- ST_REQ:
  - dc_req_vld_o = 1, dc_req_we_o = 1, with the captured address and data; hold until dc_req_rdy_i.
  - On dc_req_rdy_i: next state ST_RSP.
- ST_RSP:
  - On dc_rsp_vld_i: next cycle sdq_clear_vld_o = 1 with the captured index; return to IDLE.
- flush_i does not affect ST_FETCH, ST_REQ or ST_RSP; committed stores always complete.
- ld_rsp_vld_o and sdq_clear_vld_o are single-cycle pulses.
- Back-to-back transactions: the minimum load occupancy is 3 cycles (IDLE, LD_REQ, LD_RSP). A new grant is possible in the cycle the FSM returns to IDLE.
- dc_rsp_vld_i received outside LD_RSP or ST_RSP is ignored.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined, three 32-bit output ports are added. All reset to 0 and wrap on overflow.
  - perf_ld_grants_o: increments on each load accept.
  - perf_st_grants_o: increments on each ST_FETCH to ST_REQ transition.
  - perf_starve_o: increments on each store forced by starve_cnt == STARVE_LIMIT.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single load: ld_req_vld_i = 1, addr 0x100, tag 3; dc_req_rdy_i = 1; dc_rsp_vld_i with data 0xDEADBEEF 2 cycles later -> ld_req_rdy_o pulses once; dc_req_we_o = 0, dc_req_addr_o = 0x100; one cycle after the response, ld_rsp_vld_o = 1 with 0xDEADBEEF and tag 3.
- Store drain: st_pending_i = 1, no load; SDQ returns idx 5, addr 0x40, data 0x1234 -> sdq_issue_en_o pulses; dc_req_we_o = 1 with addr 0x40 and data 0x1234; after the ack, sdq_clear_vld_o pulses with idx 5.
- Starvation: ld_req_vld_i held high, st_pending_i = 1, STARVE_LIMIT = 4 -> exactly 4 load grants, then a store is selected, and starve_cnt returns to 0.
- SDQ full: ld_req_vld_i = 1, st_pending_i = 1, sdq_full_i = 1 -> store selected first, and the load waits with ld_req_rdy_o = 0.
- Flush: flush_i in LD_RSP, then dc_rsp_vld_i -> no ld_rsp_vld_o and FSM returns to IDLE. flush_i in ST_REQ -> the store still completes and sdq_clear_vld_o still pulses.
- Reset mid-store: rst_ni low while in ST_REQ -> dc_req_vld_o = 0 immediately (asynchronous), FSM in IDLE, no sdq_clear_vld_o.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single data-cache request port between load-unit requests and
//   committed stores draining from the store data queue (SDQ). Loads have
//   priority; a starvation counter and an SDQ-full override force stores
//   through. Only one cache transaction is outstanding at a time.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both 1.
//   The valid side holds its payload stable until that cycle. It may not
//   withdraw valid before then, except that a flush may withdraw a load request.
//
// Ports
//   clk_i, rst_ni             clock (rising edge), async active-low reset
//   flush_i                   squashes the in-flight load only
//   ld_req_*                  load request (vld/rdy/addr/tag)
//   ld_rsp_*                  registered load response (vld pulse/data/tag)
//   st_pending_i, sdq_full_i  SDQ head ready to drain / SDQ full
//   sdq_issue_en_o            one-cycle pulse asking the SDQ for its head
//   sdq_issue_*_i             issued entry, one cycle after sdq_issue_en_o
//   sdq_clear_*_o             registered clear-entry pulse and index
//   dc_req_*, dc_rsp_*        data-cache request / response port
//   perf_*_o                  performance counters (only with ARB_PERF_CNT_EN)
//   dbg_state_o               current FSM state (debug observation)
//
// Optional feature macro: ARB_PERF_CNT_EN adds perf_ld_grants_o,
//   perf_st_grants_o and perf_starve_o (32-bit, wrapping).
module mem_port_arbiter #(
  parameter int TAG_W        = 4,
  parameter int SDQ_ENTRIES  = 8,
  parameter int STARVE_LIMIT = 4,
  parameter int IDX_W        = $clog2(SDQ_ENTRIES)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              ld_req_vld_i,
  output logic              ld_req_rdy_o,
  input  logic [31:0]       ld_req_addr_i,
  input  logic [TAG_W-1:0]  ld_req_tag_i,
  output logic              ld_rsp_vld_o,
  output logic [31:0]       ld_rsp_data_o,
  output logic [TAG_W-1:0]  ld_rsp_tag_o,
  input  logic              st_pending_i,
  input  logic              sdq_full_i,
  output logic              sdq_issue_en_o,
  input  logic              sdq_issue_vld_i,
  input  logic [31:0]       sdq_issue_addr_i,
  input  logic [31:0]       sdq_issue_data_i,
  input  logic [IDX_W-1:0]  sdq_issue_idx_i,
  output logic              sdq_clear_vld_o,
  output logic [IDX_W-1:0]  sdq_clear_idx_o,
  output logic              dc_req_vld_o,
  input  logic              dc_req_rdy_i,
  output logic              dc_req_we_o,
  output logic [31:0]       dc_req_addr_o,
  output logic [31:0]       dc_req_wdata_o,
  input  logic              dc_rsp_vld_i,
  input  logic [31:0]       dc_rsp_data_i,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]       perf_ld_grants_o,
  output logic [31:0]       perf_st_grants_o,
  output logic [31:0]       perf_starve_o,
`endif
  output logic [2:0]        dbg_state_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LD_REQ   = 3'd1,
    S_LD_RSP   = 3'd2,
    S_ST_FETCH = 3'd3,
    S_ST_REQ   = 3'd4,
    S_ST_RSP   = 3'd5
  } state_t;

  state_t             state_q;
  logic [31:0]        addr_q;
  logic [31:0]        data_q;
  logic [TAG_W-1:0]   tag_q;
  logic [IDX_W-1:0]   idx_q;
  logic               squash_q;
  logic [CNT_W-1:0]   starve_cnt_q;

  logic in_idle;
  logic starve_hit;
  logic store_sel;
  logic ld_take;
  logic ld_phase;
  logic st_phase;

  assign in_idle    = (state_q == S_IDLE);
  assign starve_hit = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
  assign store_sel  = in_idle & st_pending_i &
                      (~ld_req_vld_i | sdq_full_i | starve_hit);
  assign ld_take    = in_idle & ld_req_vld_i & ~store_sel & ~flush_i;

  // The FSM sits in IDLE during reset. The combinational grants are also
  // masked by rst_ni, so every output reads 0 while reset is asserted.
  assign ld_req_rdy_o   = ld_take & rst_ni;
  assign sdq_issue_en_o = store_sel & rst_ni;

  assign ld_phase       = (state_q == S_LD_REQ);
  assign st_phase       = (state_q == S_ST_REQ);
  assign dc_req_vld_o   = ld_phase | st_phase;
  assign dc_req_we_o    = st_phase;
  assign dc_req_addr_o  = dc_req_vld_o ? addr_q : 32'd0;
  assign dc_req_wdata_o = st_phase ? data_q : 32'd0;
  assign dbg_state_o    = state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      data_q          <= '0;
      tag_q           <= '0;
      idx_q           <= '0;
      squash_q        <= 1'b0;
      starve_cnt_q    <= '0;
      ld_rsp_vld_o    <= 1'b0;
      ld_rsp_data_o   <= '0;
      ld_rsp_tag_o    <= '0;
      sdq_clear_vld_o <= 1'b0;
      sdq_clear_idx_o <= '0;
    end else begin
      ld_rsp_vld_o    <= 1'b0;
      sdq_clear_vld_o <= 1'b0;

      // The count only measures loads that overtake a waiting store.
      if (!st_pending_i || store_sel) begin
        starve_cnt_q <= '0;
      end else if (ld_take && !starve_hit) begin
        starve_cnt_q <= starve_cnt_q + CNT_W'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (store_sel) begin
            state_q <= S_ST_FETCH;
          end else if (ld_take) begin
            addr_q  <= ld_req_addr_i;
            tag_q   <= ld_req_tag_i;
            state_q <= S_LD_REQ;
          end
        end
        S_LD_REQ: begin
          // If flush arrives in the same cycle as the cache handshake, the
          // request has already gone out. Keep the protocol intact and discard
          // the response later.
          if (dc_req_rdy_i) begin
            squash_q <= flush_i;
            state_q  <= S_LD_RSP;
          end else if (flush_i) begin
            state_q <= S_IDLE;
          end
        end
        S_LD_RSP: begin
          if (dc_rsp_vld_i) begin
            if (!(squash_q || flush_i)) begin
              ld_rsp_vld_o  <= 1'b1;
              ld_rsp_data_o <= dc_rsp_data_i;
              ld_rsp_tag_o  <= tag_q;
            end
            squash_q <= 1'b0;
            state_q  <= S_IDLE;
          end else if (flush_i) begin
            squash_q <= 1'b1;
          end
        end
        S_ST_FETCH: begin
          if (sdq_issue_vld_i) begin
            addr_q  <= sdq_issue_addr_i;
            data_q  <= sdq_issue_data_i;
            idx_q   <= sdq_issue_idx_i;
            state_q <= S_ST_REQ;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ST_REQ: begin
          if (dc_req_rdy_i) state_q <= S_ST_RSP;
        end
        S_ST_RSP: begin
          if (dc_rsp_vld_i) begin
            sdq_clear_vld_o <= 1'b1;
            sdq_clear_idx_o <= idx_q;
            state_q         <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_ld_grants_o <= '0;
      perf_st_grants_o <= '0;
      perf_starve_o    <= '0;
    end else begin
      if (ld_take) perf_ld_grants_o <= perf_ld_grants_o + 32'd1;
      if (state_q == S_ST_FETCH && sdq_issue_vld_i)
        perf_st_grants_o <= perf_st_grants_o + 32'd1;
      // This counts only stores that the starvation limit alone forced ahead of a load.
      if (store_sel && ld_req_vld_i && !sdq_full_i && starve_hit)
        perf_starve_o <= perf_starve_o + 32'd1;
    end
  end
`endif

endmodule
